// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_ctrl_pkg;

    // Controller states; one-hot outputs are decoded from these.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUT    = 3'd4,
        ST_CLEAR  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // Command opcodes; codes above OP_LDB are illegal.
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_CLR = 3'd3;
    localparam logic [2:0] OP_LDA = 3'd4;
    localparam logic [2:0] OP_LDB = 3'd5;

    // Largest hold the 4-bit OUT counter can express.
    localparam int OUT_HOLD_MAX = 15;

    // Datapath control word driven by the controller.
    typedef struct packed {
        logic ai;
        logic bi;
        logic ar;
        logic br;
        logic sub;
        logic so;
        logic done;
        logic err;
    } ctrl_t;

    // Moore decode: controls asserted in a given state. sub only follows the
    // latched flag inside the arithmetic path states; everything else is 0.
    function automatic ctrl_t state_ctrl(state_e st, logic sub_lat);
        ctrl_t c;
        c = '0;
        case (st)
            ST_LOAD_A: begin
                c.ai  = 1'b1;
                c.sub = sub_lat;
            end
            ST_LOAD_B: begin
                c.bi  = 1'b1;
                c.sub = sub_lat;
            end
            ST_EXEC: begin
                c.sub = sub_lat;
            end
            ST_OUT: begin
                c.so  = 1'b1;
                c.sub = sub_lat;
            end
            ST_CLEAR: begin
                c.ar = 1'b1;
                c.br = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
            ST_ERR:  c.err  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequences operand load / add-sub / output-enable controls for a small ALU from single commands.
// Latency: ADD/SUB accept-to-done 4+OUT_HOLD cycles; LDA/LDB/CLR 2; NOP 1; illegal op err after 1.
// Backpressure: cmd_ready high only in IDLE; one idle cycle separates back-to-back commands.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int OUT_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    output logic       Ai,
    output logic       Bi,
    output logic       Ar,
    output logic       Br,
    output logic       sub,
    output logic       So,
    output logic       done,
    output logic       err,
    output logic [7:0] op_count
);

    // Out-of-range parameters are clamped so the 4-bit counter never wraps.
    localparam int HOLD_CLAMP = (OUT_HOLD < 1) ? 1 :
                                (OUT_HOLD > OUT_HOLD_MAX) ? OUT_HOLD_MAX : OUT_HOLD;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CLAMP - 1);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] hold_q, hold_d;
    logic       sub_lat_q, sub_lat_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       rdy_q, rdy_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;
    logic       arith;

    assign accept = cmd_valid && rdy_q;
    assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Next-state, command latch, hold counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hold_d    = hold_q;
        sub_lat_d = sub_lat_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = cmd_op;
                    sub_lat_d = (cmd_op == OP_SUB);
                    case (cmd_op)
                        OP_NOP:                 state_d = ST_DONE;
                        OP_ADD, OP_SUB, OP_LDA: state_d = ST_LOAD_A;
                        OP_LDB:                 state_d = ST_LOAD_B;
                        OP_CLR:                 state_d = ST_CLEAR;
                        default:                state_d = ST_ERR;
                    endcase
                end
            end
            ST_LOAD_A: state_d = arith ? ST_LOAD_B : ST_DONE;
            ST_LOAD_B: state_d = arith ? ST_EXEC : ST_DONE;
            ST_EXEC: begin
                state_d = ST_OUT;
                hold_d  = HOLD_LOAD;
            end
            ST_OUT: begin
                if (hold_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE: begin
                state_d   = ST_IDLE;
                sub_lat_d = 1'b0;
                cnt_d     = cnt_q + 8'd1;
            end
            ST_ERR: begin
                state_d   = ST_IDLE;
                sub_lat_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from the next state so they register alongside it.
        ctrl_d = state_ctrl(state_d, sub_lat_d);
        rdy_d  = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops every control immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            hold_q    <= 4'd0;
            sub_lat_q <= 1'b0;
            ctrl_q    <= '0;
            rdy_q     <= 1'b1;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hold_q    <= hold_d;
            sub_lat_q <= sub_lat_d;
            ctrl_q    <= ctrl_d;
            rdy_q     <= rdy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign Ai        = ctrl_q.ai;
    assign Bi        = ctrl_q.bi;
    assign Ar        = ctrl_q.ar;
    assign Br        = ctrl_q.br;
    assign sub       = ctrl_q.sub;
    assign So        = ctrl_q.so;
    assign done      = ctrl_q.done;
    assign err       = ctrl_q.err;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl with OUT_HOLD=2.
// Latency: expected per-cycle output vectors are queued, then popped at each falling edge.
// Backpressure: commands are offered only while the controller sits in IDLE.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       Ai, Bi, Ar, Br, sub, So, done, err;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic [16:0] msk_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.OUT_HOLD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .Ai       (Ai),
        .Bi       (Bi),
        .Ar       (Ar),
        .Br       (Br),
        .sub      (sub),
        .So       (So),
        .done     (done),
        .err      (err),
        .op_count (op_count)
    );

    function automatic logic [16:0] observed();
        return {cmd_ready, Ai, Bi, Ar, Br, sub, So, done, err, op_count};
    endfunction

    // Queue one expected cycle; rdy or cnt of -1 means "not compared".
    task automatic push(input string tag, input int rdy,
                        input bit ai, input bit bi, input bit ar, input bit br,
                        input bit sb, input bit so, input bit dn, input bit er,
                        input int cnt);
        logic [16:0] e;
        logic [16:0] m;
        logic [7:0]  c;
        c = (cnt < 0) ? 8'd0 : 8'(cnt & 255);
        e = {(rdy == 1), ai, bi, ar, br, sb, so, dn, er, c};
        m = 17'h1FFFF;
        if (rdy < 0) m[16] = 1'b0;
        if (cnt < 0) m[7:0] = 8'd0;
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    task automatic compare_now();
        logic [16:0] e, m, o;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected a queued entry", observed());
        end else begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            assert ((o & m) === (e & m)) else begin
                errors++;
                $error("FAIL %s: observed {rdy,Ai,Bi,Ar,Br,sub,So,done,err,cnt}=%h expected %h mask %h",
                       t, o, e, m);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_now();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;

        // Reset state while rst_n is held low.
        #12;
        push("reset_hold", -1, 0,0,0,0, 0,0,0,0, 0);
        compare_now();
        @(negedge clk);
        rst_n = 1'b1;
        push("reset_release", 1, 0,0,0,0, 0,0,0,0, 0);
        run(1);

        // ADD: Ai c1, Bi c2, EXEC c3, So c4-5, done c6.
        cmd_valid = 1'b1; cmd_op = 3'd1;
        push("add_c1_ai", 0, 1,0,0,0, 0,0,0,0, 0);
        run(1);
        cmd_valid = 1'b0;
        push("add_c2_bi",   0, 0,1,0,0, 0,0,0,0, 0);
        push("add_c3_exec", 0, 0,0,0,0, 0,0,0,0, 0);
        push("add_c4_so",   0, 0,0,0,0, 0,1,0,0, 0);
        push("add_c5_so",   0, 0,0,0,0, 0,1,0,0, 0);
        push("add_c6_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("add_c7_idle", 1, 0,0,0,0, 0,0,0,0, 1);
        run(6);

        // SUB then ADD with cmd_valid held; opcode changes mid-SUB must be ignored.
        cmd_valid = 1'b1; cmd_op = 3'd2;
        push("sub_c1_ai", 0, 1,0,0,0, 1,0,0,0, 1);
        run(1);
        cmd_op = 3'd1;
        push("sub_c2_bi",   0, 0,1,0,0, 1,0,0,0, 1);
        push("sub_c3_exec", 0, 0,0,0,0, 1,0,0,0, 1);
        push("sub_c4_so",   0, 0,0,0,0, 1,1,0,0, 1);
        push("sub_c5_so",   0, 0,0,0,0, 1,1,0,0, 1);
        push("sub_c6_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("sub_c7_idle", 1, 0,0,0,0, 0,0,0,0, 2);
        push("add2_c8_ai",  0, 1,0,0,0, 0,0,0,0, 2);
        run(7);
        cmd_valid = 1'b0;
        push("add2_c9_bi",    0, 0,1,0,0, 0,0,0,0, 2);
        push("add2_c10_exec", 0, 0,0,0,0, 0,0,0,0, 2);
        push("add2_c11_so",   0, 0,0,0,0, 0,1,0,0, 2);
        push("add2_c12_so",   0, 0,0,0,0, 0,1,0,0, 2);
        push("add2_c13_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("add2_c14_idle", 1, 0,0,0,0, 0,0,0,0, 3);
        run(6);

        // CLR: Ar=Br one cycle, then done.
        cmd_valid = 1'b1; cmd_op = 3'd3;
        push("clr_c1", 0, 0,0,1,1, 0,0,0,0, 3);
        run(1);
        cmd_valid = 1'b0;
        push("clr_c2_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("clr_c3_idle", 1, 0,0,0,0, 0,0,0,0, 4);
        run(2);

        // Illegal opcodes 7 and 6: err pulse only, count unchanged.
        cmd_valid = 1'b1; cmd_op = 3'd7;
        push("ill7_c1_err", 0, 0,0,0,0, 0,0,0,1, 4);
        run(1);
        cmd_valid = 1'b0;
        push("ill7_c2_ready", 1, 0,0,0,0, 0,0,0,0, 4);
        run(1);
        cmd_valid = 1'b1; cmd_op = 3'd6;
        push("ill6_c1_err", 0, 0,0,0,0, 0,0,0,1, 4);
        run(1);
        cmd_valid = 1'b0;
        push("ill6_c2_ready", 1, 0,0,0,0, 0,0,0,0, 4);
        run(1);

        // LDA and LDB: single load then done.
        cmd_valid = 1'b1; cmd_op = 3'd4;
        push("lda_c1", 0, 1,0,0,0, 0,0,0,0, 4);
        run(1);
        cmd_valid = 1'b0;
        push("lda_c2_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("lda_c3_idle", 1, 0,0,0,0, 0,0,0,0, 5);
        run(2);
        cmd_valid = 1'b1; cmd_op = 3'd5;
        push("ldb_c1", 0, 0,1,0,0, 0,0,0,0, 5);
        run(1);
        cmd_valid = 1'b0;
        push("ldb_c2_done", 0, 0,0,0,0, 0,0,1,0, -1);
        push("ldb_c3_idle", 1, 0,0,0,0, 0,0,0,0, 6);
        run(2);

        // NOP: done one cycle after acceptance.
        cmd_valid = 1'b1; cmd_op = 3'd0;
        push("nop_c1_done", 0, 0,0,0,0, 0,0,1,0, -1);
        run(1);
        cmd_valid = 1'b0;
        push("nop_c2_idle", 1, 0,0,0,0, 0,0,0,0, 7);
        run(1);

        // Reset asserted during cycle 4 of an ADD.
        cmd_valid = 1'b1; cmd_op = 3'd1;
        push("rst_add_c1", 0, 1,0,0,0, 0,0,0,0, 7);
        run(1);
        cmd_valid = 1'b0;
        push("rst_add_c2", 0, 0,1,0,0, 0,0,0,0, 7);
        push("rst_add_c3", 0, 0,0,0,0, 0,0,0,0, 7);
        run(2);
        @(posedge clk);
        #2;
        push("rst_add_c4_so", 0, 0,0,0,0, 0,1,0,0, 7);
        compare_now();
        rst_n = 1'b0;
        #1;
        push("rst_async_drop", -1, 0,0,0,0, 0,0,0,0, 0);
        compare_now();
        @(negedge clk);
        push("rst_held", -1, 0,0,0,0, 0,0,0,0, 0);
        compare_now();
        rst_n = 1'b1;
        push("rst_after_c1", 1, 0,0,0,0, 0,0,0,0, 0);
        push("rst_after_c2", 1, 0,0,0,0, 0,0,0,0, 0);
        run(2);

        // 256 back-to-back NOPs: count wraps 255 -> 0.
        cmd_valid = 1'b1; cmd_op = 3'd0;
        for (int i = 1; i <= 256; i++) begin
            push("nopwrap_done", 0, 0,0,0,0, 0,0,1,0, -1);
            push((i == 255) ? "nopwrap_255" : (i == 256) ? "nopwrap_256" : "nopwrap_idle",
                 1, 0,0,0,0, 0,0,0,0, i & 255);
            run(2);
        end
        cmd_valid = 1'b0;
        push("final_idle", 1, 0,0,0,0, 0,0,0,0, 0);
        run(1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
- REQ-001 SHALL have parameter: OUT_HOLD, default 2, number of cycles So is held high (legal range 1-15).
- REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
- REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL have port: cmd_valid  input  1  command offered.
- REQ-005 SHALL have port: cmd_ready  output  1  block can accept a command.
- REQ-006 SHALL have port: cmd_op  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 CLR, 4 LDA, 5 LDB, 6-7 illegal.
- REQ-007 SHALL have ports: Ai, Bi  output  1 each  load-enable for the A and B operand registers.
- REQ-008 SHALL have ports: Ar, Br  output  1 each  clear for the A and B operand registers.
- REQ-009 SHALL have ports: sub  output  1  1 = subtract, 0 = add; So  output  1  result output enable.
- REQ-010 SHALL have ports: done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-op pulse.
- REQ-011 SHALL have port: op_count  output  8  count of completed legal commands.

Function
- REQ-012 SHALL be a Moore FSM with registered outputs; states IDLE, LOAD_A, LOAD_B, EXEC, OUT, CLEAR, DONE, ERR.
- REQ-013 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready, and cmd_op is sampled only then.
- REQ-014 ADD/SUB SHALL sequence LOAD_A (Ai=1) -> LOAD_B (Bi=1) -> EXEC -> OUT (So=1 for exactly OUT_HOLD cycles) -> DONE (done=1) -> IDLE; accept-to-done latency = 4+OUT_HOLD cycles.
- REQ-015 SHALL latch sub at acceptance (1 for SUB, 0 for ADD) and hold it constant from LOAD_A through OUT; sub=0 in all other states.
- REQ-016 CLR SHALL go to CLEAR (Ar=Br=1 for one cycle) -> DONE.
- REQ-017 LDA SHALL go to LOAD_A -> DONE; LDB SHALL go to LOAD_B -> DONE.
- REQ-018 NOP SHALL go directly to DONE (done one cycle after acceptance).
- REQ-019 Illegal ops SHALL go to ERR (err=1 for one cycle, no control outputs asserted) -> IDLE; the command is consumed, op_count unchanged, done not asserted.
- REQ-020 Ai and Ar SHALL never be high together; likewise Bi and Br; So SHALL never be high in any state other than OUT.
- REQ-021 OUT hold SHALL use a 4-bit down-counter loaded with OUT_HOLD-1 on entry to OUT; exit when it reaches 0.
- REQ-022 op_count SHALL increment by 1 in each DONE cycle, wrapping 255 -> 0.
- REQ-023 With cmd_valid held high, back-to-back commands SHALL be accepted in the IDLE cycle following DONE/ERR (one idle cycle between commands).
- REQ-024 All control outputs not named for the current state SHALL be 0.

Reset
- REQ-025 rst_n low SHALL asynchronously force state IDLE, Ai=Bi=Ar=Br=sub=So=done=err=0, op_count=0, hold counter 0; cmd_ready=1 from the first cycle after release.
- REQ-026 Reset asserted mid-operation SHALL abandon the command with no done/err pulse.

Structure
- REQ-027 Shared package alu_ctrl_pkg SHALL hold the state enum, the 3-bit opcode constants, and the OUT_HOLD maximum (15).
- REQ-028 Implementation SHALL be a single module; no sub-module is warranted.

Verification
- REQ-029 ADD, OUT_HOLD=2, accepted at edge 0 -> Ai cycle 1, Bi cycle 2, EXEC cycle 3 (sub=0), So cycles 4-5, done cycle 6, op_count=1.
- REQ-030 SUB then ADD with cmd_valid held -> sub=1 in cycles 1-5 of first command, second accepted at edge 7, its sub=0 throughout.
- REQ-031 CLR -> Ar=Br=1 exactly cycle 1, done cycle 2, Ai/Bi never high.
- REQ-032 cmd_op=7 -> err=1 cycle 1 only, no control outputs, op_count unchanged, cmd_ready back at cycle 2.
- REQ-033 rst_n low during cycle 4 of an ADD -> So falls without a clock edge, op_count=0, no done pulse, IDLE after release.
- REQ-034 256 NOPs -> op_count reads 255 after 255th, 0 after 256th.
